// File: rtl/mem_req_responder.sv
// Memory-side responder for a byte-serial request bus.
// A request is an address high byte (bit 7 = write flag), an address low byte,
// and for writes one data byte. Reads return after WAIT_CYCLES wait states.
// Optional feature macro: MEM_RESP_WRAP_EN (addresses alias modulo MEM_DEPTH,
// rangeErr never asserts). Without it, addresses >= MEM_DEPTH are out of range.
module mem_req_responder #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] busIn,
  input  logic                  reqValid,
  output logic [DATA_WIDTH-1:0] busOut,
  output logic                  respValid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  rangeErr
);

  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned HI_W      = ADDR_WIDTH - DATA_WIDTH;
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    WDATA,
    WAIT,
    RESP
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic                    wr_flag, wr_flag_n;
  logic [3:0]              cnt, cnt_n;
  logic [DATA_WIDTH-1:0]   bus_n;
  logic                    resp_n, err_n, busy_n;
  logic                    mem_we;
  logic [IDX_W-1:0]        idx;
  logic                    oor;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // addrOut doubles as the latched transaction address
  assign idx = addrOut[IDX_W-1:0];

`ifdef MEM_RESP_WRAP_EN
  assign oor = 1'b0;
`else
  assign oor = ({1'b0, addrOut} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
`endif

  // State and registered outputs; reset drops any partial request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addrOut   <= '0;
      wr_flag   <= 1'b0;
      cnt       <= '0;
      busOut    <= '0;
      respValid <= 1'b0;
      rangeErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      addrOut   <= addr_n;
      wr_flag   <= wr_flag_n;
      cnt       <= cnt_n;
      busOut    <= bus_n;
      respValid <= resp_n;
      rangeErr  <= err_n;
      busy      <= busy_n;
    end
  end

  // RAM write port; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[idx] <= busIn;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    addr_n    = addrOut;
    wr_flag_n = wr_flag;
    cnt_n     = cnt;
    bus_n     = busOut;
    resp_n    = 1'b0;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqValid) begin
          addr_n    = {busIn[HI_W-1:0], addrOut[DATA_WIDTH-1:0]};
          wr_flag_n = busIn[DATA_WIDTH-1];
          state_n   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (reqValid) begin
          addr_n = {addrOut[ADDR_WIDTH-1:DATA_WIDTH], busIn};
          cnt_n  = '0;
          if (wr_flag)               state_n = WDATA;
          else if (WAIT_CYCLES == 0) state_n = RESP;
          else                       state_n = WAIT;
        end
      end
      WDATA: begin
        if (reqValid) begin
          mem_we  = !oor;
          bus_n   = busIn;
          resp_n  = 1'b1;
          err_n   = oor;
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_n   = '0;
          state_n = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        bus_n   = oor ? '0 : mem[idx];
        resp_n  = 1'b1;
        err_n   = oor;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/mem_req_responder.md
# mem_req_responder

Memory-side responder for the CPU's byte-serial memory request interface. It receives a 15-bit address as two byte phases plus an optional write-data byte on an 8-bit bus, services the request from an internal RAM, and returns read data with a one-cycle valid pulse after a fixed number of wait states. It is the memory end of the datapath's request/read-bus pair, used in on-chip test configurations and as the bench memory model.

## Interface
- ADDR_WIDTH, 15, request address width
- DATA_WIDTH, 8, bus and memory word width
- MEM_DEPTH, 256, RAM words; power of two, at most 2^ADDR_WIDTH
- WAIT_CYCLES, 2, wait states inserted before read data; 0..15

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- busIn  in  DATA_WIDTH  request byte: address high, address low, or write data
- reqValid  in  1  busIn holds a request byte this cycle
- busOut  out  DATA_WIDTH  read data, or echoed write data; valid while respValid
- respValid  out  1  one-cycle pulse marking completion
- busy  out  1  high whenever the state is not IDLE
- addrOut  out  ADDR_WIDTH  latched address of the current or last transaction
- rangeErr  out  1  one-cycle pulse, alongside respValid, for an out-of-range address

## Operation
- States: IDLE, ADDR_LO, WDATA, WAIT, RESP.
- IDLE: reqValid=1 latches busIn[6:0] into addr[14:8] and busIn[7] as the write flag, then goes to ADDR_LO.
- ADDR_LO: reqValid=1 latches busIn into addr[7:0]. If the write flag is set, go to WDATA. Otherwise go to WAIT, or to RESP when WAIT_CYCLES=0.
- WDATA: reqValid=1 writes busIn to mem[index] (write dropped if out of range), sets busOut=busIn, pulses respValid, and returns to IDLE.
- WAIT: counts WAIT_CYCLES cycles, then goes to RESP. reqValid is ignored.
- RESP: busOut=mem[index] (0x00 if out of range), respValid=1 for one cycle, rangeErr as applicable, then IDLE. reqValid is ignored.
- In ADDR_LO and WDATA, reqValid=0 holds the state. There is no timeout.
- Index: addr[log2(MEM_DEPTH)-1:0]. Out of range means addr ≥ MEM_DEPTH; see Configuration.
- The RAM is not cleared by reset; contents survive a reset.

## Timing
- Reset values: busOut=0, respValid=0, busy=0, addrOut=0, rangeErr=0, state=IDLE, wait counter=0.
- All outputs are registered.
- Read: low address byte sampled at edge E. respValid/busOut/rangeErr assert at edge E+WAIT_CYCLES+1 and deassert at the next edge.
- Write: data byte sampled at edge W; mem and respValid update at W. The pulse lasts one cycle.
- busy rises at the edge that accepts the first byte and falls at the edge where respValid rises.
- Back-to-back: a new first byte is accepted in the cycle after the respValid edge, so the minimum read period is WAIT_CYCLES+3 cycles.
- addrOut updates at each address-byte acceptance (high half, then low half) and holds until the next transaction.
- Reset mid-transaction (any state): next edge returns to IDLE, drops the partial request, performs no write and no response pulse.
- Reset takes priority over reqValid on the same edge.

## Configuration
- MEM_RESP_WRAP_EN defined: no address is out of range. Upper address bits are ignored, addresses alias modulo MEM_DEPTH, and rangeErr is tied 0.
- MEM_RESP_WRAP_EN undefined:
  - Out-of-range reads return 0x00 with rangeErr pulsed alongside respValid.
  - Out-of-range writes are discarded, with rangeErr pulsed alongside respValid.

## Test plan
- Write then read, WAIT_CYCLES=2: reset low 1 cycle; send 0x80,0x12,0xA5, then 0x00,0x12 (low byte at edge E). Expect respValid only at E+3, busOut=0xA5, rangeErr=0, addrOut=0x0012.
- Zero-wait latency, WAIT_CYCLES=0: read of a previously written 0x3C at 0x0040. Expect respValid at E+1; busy high for exactly 2 cycles.
- Out of range, MEM_DEPTH=256: write 0x77 to 0x0100, then read 0x0100 and 0x0000 (0x0000 preloaded with 0x11).
  - Without macro: both 0x0100 responses pulse rangeErr; the read returns 0x00 and 0x0000 still reads 0x11.
  - With macro: the read of 0x0100 returns 0x77, 0x0000 also reads 0x77, and rangeErr stays 0.
- Reset mid-transaction: send 0x80,0x05, then reset in WDATA. Expect busy=0 and no respValid. Then read 0x0005: it returns its pre-reset value.
- Ignored bytes: pulse reqValid with 0xFF during WAIT and RESP. Expect the response unchanged and the state IDLE afterwards. A following read of 0x0012 returns 0xA5.
- Stall and max address: write 0x5A to 0x7FFF (bytes 0xFF,0xFF,0x5A) with 3 idle cycles between bytes. Expect the state held between bytes, addrOut=0x7FFF, and the write aliased to index 0xFF (with macro).
